// File: rtl/sonic_pkg.sv
// Shared constants and FSM state type for the ultrasonic echo-to-distance path.
package sonic_pkg;

    localparam int unsigned DIV_CONST_DEF = 5800;
    localparam int unsigned MAX_CM_DEF    = 400;
    localparam int unsigned DIST_W        = 10;
    localparam int unsigned ECHO_W        = 33;
    localparam int unsigned DIVD_W        = 34;
    localparam int unsigned HIST_N        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/udiv_seq.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, N_W cycles after start_i.
module udiv_seq #(
    parameter int unsigned N_W = 34,
    parameter int unsigned D_W = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic [N_W-1:0] quotient_o,
    output logic           done_o
);

    localparam int unsigned CNT_W = $clog2(N_W + 1);

    logic [D_W-1:0]   rem_q, rem_d;
    logic [N_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [D_W:0]     shl_c;
    logic [D_W:0]     dvs_c;

    // Dividend bits shift out of quo_q into the remainder while quotient bits shift in.
    always_comb begin
        shl_c  = {rem_q, quo_q[N_W-1]};
        dvs_c  = {1'b0, divisor_i};
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            cnt_d = CNT_W'(N_W);
        end else if (cnt_q != '0) begin
            if (shl_c >= dvs_c) begin
                rem_d = D_W'(shl_c - dvs_c);
                quo_d = {quo_q[N_W-2:0], 1'b1};
            end else begin
                rem_d = shl_c[D_W-1:0];
                quo_d = {quo_q[N_W-2:0], 1'b0};
            end
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/echo_to_distance.sv
// Converts an echo pulse width to a rounded, saturated distance in cm plus a 4-sample moving average.
module echo_to_distance
    import sonic_pkg::*;
#(
    parameter int unsigned DIV_CONST = DIV_CONST_DEF,
    parameter int unsigned MAX_CM    = MAX_CM_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ECHO_W-1:0] echo_time,
    input  logic              e_done,
    input  logic              re_idle,
    output logic [DIST_W-1:0] dist_cm,
    output logic [DIST_W-1:0] dist_avg,
    output logic              dist_valid,
    output logic              out_of_range,
    output logic              timeout,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned DVSR_W = $clog2(DIV_CONST + 1);
    localparam int unsigned FILL_W = $clog2(HIST_N + 1);
    localparam int unsigned AVG_SH = $clog2(HIST_N);
    localparam int unsigned SUM_W  = DIST_W + AVG_SH;

    state_e            state_q, state_d;
    logic              e_done_q, re_idle_q;
    logic              e_rise_c, re_rise_c;
    logic              div_start_c, div_done;
    logic [DIVD_W-1:0] dividend_c, quotient;
    logic              sat_c;
    logic [DIST_W-1:0] new_cm_c;
    logic [SUM_W-1:0]  sum_c;

    logic [DIST_W-1:0] dist_cm_q, dist_cm_d, dist_avg_q, dist_avg_d;
    logic              dist_valid_q, dist_valid_d, oor_q, oor_d;
    logic              timeout_q, timeout_d, overrun_q, overrun_d, busy_q, busy_d;
    logic [DIST_W-1:0] hist_q [HIST_N];
    logic [DIST_W-1:0] hist_d [HIST_N];
    logic [FILL_W-1:0] fill_q, fill_d;

    assign e_rise_c   = e_done & ~e_done_q;
    assign re_rise_c  = re_idle & ~re_idle_q;
    // Adding half the divisor turns the floor division into round-half-up.
    assign dividend_c = DIVD_W'(echo_time) + DIVD_W'(DIV_CONST / 2);
    assign sat_c      = quotient > DIVD_W'(MAX_CM);
    assign new_cm_c   = sat_c ? DIST_W'(MAX_CM) : quotient[DIST_W-1:0];

    udiv_seq #(
        .N_W (DIVD_W),
        .D_W (DVSR_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_c),
        .dividend_i (dividend_c),
        .divisor_i  (DVSR_W'(DIV_CONST)),
        .quotient_o (quotient),
        .done_o     (div_done)
    );

    // Next-state, history update and output staging.
    always_comb begin
        state_d      = state_q;
        div_start_c  = 1'b0;
        dist_valid_d = 1'b0;
        overrun_d    = 1'b0;
        timeout_d    = re_rise_c;
        dist_cm_d    = dist_cm_q;
        dist_avg_d   = dist_avg_q;
        oor_d        = oor_q;
        fill_d       = fill_q;
        sum_c        = '0;
        for (int i = 0; i < HIST_N; i++) begin
            hist_d[i] = hist_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (e_rise_c) begin
                    div_start_c = 1'b1;
                    state_d     = ST_DIV;
                end
            end
            ST_DIV: begin
                overrun_d = e_rise_c;
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                overrun_d    = e_rise_c;
                state_d      = ST_IDLE;
                dist_valid_d = 1'b1;
                dist_cm_d    = new_cm_c;
                oor_d        = sat_c;
                hist_d[0]    = new_cm_c;
                for (int i = 1; i < HIST_N; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                if (fill_q != FILL_W'(HIST_N)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                for (int i = 0; i < HIST_N; i++) begin
                    sum_c = sum_c + SUM_W'(hist_d[i]);
                end
                dist_avg_d = (fill_d == FILL_W'(HIST_N)) ? DIST_W'(sum_c >> AVG_SH) : new_cm_c;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            e_done_q     <= 1'b0;
            re_idle_q    <= 1'b0;
            dist_cm_q    <= '0;
            dist_avg_q   <= '0;
            dist_valid_q <= 1'b0;
            oor_q        <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            fill_q       <= '0;
            for (int i = 0; i < HIST_N; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            e_done_q     <= e_done;
            re_idle_q    <= re_idle;
            dist_cm_q    <= dist_cm_d;
            dist_avg_q   <= dist_avg_d;
            dist_valid_q <= dist_valid_d;
            oor_q        <= oor_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            fill_q       <= fill_d;
            for (int i = 0; i < HIST_N; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign dist_cm      = dist_cm_q;
    assign dist_avg     = dist_avg_q;
    assign dist_valid   = dist_valid_q;
    assign out_of_range = oor_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_echo_to_distance.sv
// Self-checking bench for echo_to_distance: directed table, corner sequences and randomized conversions.
module tb_echo_to_distance;

    localparam int DIVC = 5800;
    localparam int MAXC = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] echo_time;
    logic        e_done;
    logic        re_idle;
    logic [9:0]  dist_cm;
    logic [9:0]  dist_avg;
    logic        dist_valid;
    logic        out_of_range;
    logic        timeout;
    logic        overrun;
    logic        busy;

    echo_to_distance dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .echo_time    (echo_time),
        .e_done       (e_done),
        .re_idle      (re_idle),
        .dist_cm      (dist_cm),
        .dist_avg     (dist_avg),
        .dist_valid   (dist_valid),
        .out_of_range (out_of_range),
        .timeout      (timeout),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] et;
        int          cm;
        int          oor;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int mhist[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: round-half-up division, saturation, and a plain queue of the last four results.
    task automatic model_push(input longint unsigned et, output int cm, output int oor, output int avg);
        longint unsigned q;
        q   = (et + longint'(DIVC / 2)) / longint'(DIVC);
        oor = (q > longint'(MAXC)) ? 1 : 0;
        cm  = (oor == 1) ? MAXC : int'(q);
        mhist.push_front(cm);
        if (mhist.size() > 4) void'(mhist.pop_back());
        if (mhist.size() == 4) avg = (mhist[0] + mhist[1] + mhist[2] + mhist[3]) / 4;
        else avg = cm;
    endtask

    task automatic run_conv(input logic [32:0] et, input int hold, input string tag,
                            output int a_cm, output int a_oor, output int a_avg);
        int lat;
        int ovr;
        int ecm, eoor, eavg;
        @(negedge clk);
        echo_time = et;
        e_done    = 1'b1;
        @(negedge clk);
        lat = 0;
        ovr = 0;
        chk({tag, " busy"}, 64'(busy), 64'(1));
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            lat++;
            if (overrun === 1'b1) ovr++;
        end
        e_done    = 1'b0;
        echo_time = 33'($urandom);
        while (dist_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
            if (overrun === 1'b1) ovr++;
        end
        a_cm  = int'(dist_cm);
        a_oor = int'(out_of_range);
        a_avg = int'(dist_avg);
        model_push(64'(et), ecm, eoor, eavg);
        chk({tag, " latency"}, 64'(lat), 64'(36));
        chk({tag, " overrun"}, 64'(ovr), 64'(0));
        chk({tag, " cm"}, 64'(a_cm), 64'(ecm));
        chk({tag, " oor"}, 64'(a_oor), 64'(eoor));
        chk({tag, " avg"}, 64'(a_avg), 64'(eavg));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mhist.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[10];
        int   avg_exp[4];
        int   a_cm, a_oor, a_avg;
        int   lat, tcnt, vcnt, vlat, extra;
        int   ecm, eoor, eavg;
        logic [32:0] et;

        vecs[0] = '{33'd58000,      10,  0};
        vecs[1] = '{33'd8699,       1,   0};
        vecs[2] = '{33'd8700,       2,   0};
        vecs[3] = '{33'd3000000,    400, 1};
        vecs[4] = '{33'd0,          0,   0};
        vecs[5] = '{33'd2899,       0,   0};
        vecs[6] = '{33'd2900,       1,   0};
        vecs[7] = '{33'd2317100,    400, 0};
        vecs[8] = '{33'd2322900,    400, 1};
        vecs[9] = '{33'h1FFFFFFFF,  400, 1};
        avg_exp = '{10, 20, 30, 25};

        rst_n     = 1'b0;
        e_done    = 1'b0;
        re_idle   = 1'b0;
        echo_time = '0;
        repeat (3) @(negedge clk);
        chk("rst dist_cm", 64'(dist_cm), 64'(0));
        chk("rst dist_avg", 64'(dist_avg), 64'(0));
        chk("rst dist_valid", 64'(dist_valid), 64'(0));
        chk("rst oor", 64'(out_of_range), 64'(0));
        chk("rst timeout", 64'(timeout), 64'(0));
        chk("rst overrun", 64'(overrun), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        rst_n = 1'b1;

        // Directed vectors; the first one starts from an empty history.
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].et, 1, $sformatf("tbl%0d", i), a_cm, a_oor, a_avg);
            chk($sformatf("tbl%0d cm const", i), 64'(a_cm), 64'(vecs[i].cm));
            chk($sformatf("tbl%0d oor const", i), 64'(a_oor), 64'(vecs[i].oor));
        end
        chk("tbl0 avg const", 64'(mhist.size()), 64'(4));
        @(negedge clk);
        chk("valid one-shot", 64'(dist_valid), 64'(0));
        chk("busy after done", 64'(busy), 64'(0));

        // Moving average fill-up: 10, 20, 30, 40 cm.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_conv(33'((k + 1) * 58000), 1, $sformatf("avg%0d", k), a_cm, a_oor, a_avg);
            chk($sformatf("avg%0d const", k), 64'(a_avg), 64'(avg_exp[k]));
        end

        // Second e_done five cycles into a conversion is dropped.
        @(negedge clk);
        echo_time = 33'd116000;
        e_done    = 1'b1;
        @(negedge clk);
        e_done    = 1'b0;
        echo_time = 33'd580000;
        repeat (4) @(negedge clk);
        e_done = 1'b1;
        @(negedge clk);
        chk("overrun pulse", 64'(overrun), 64'(1));
        e_done = 1'b0;
        @(negedge clk);
        chk("overrun one-shot", 64'(overrun), 64'(0));
        lat = 6;
        while (dist_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        model_push(64'd116000, ecm, eoor, eavg);
        chk("ovr latency", 64'(lat), 64'(36));
        chk("ovr cm", 64'(dist_cm), 64'(20));
        chk("ovr avg", 64'(dist_avg), 64'(eavg));
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (dist_valid === 1'b1) extra++;
        end
        chk("ovr single valid", 64'(extra), 64'(0));

        // re_idle held for ten cycles mid-conversion.
        @(negedge clk);
        echo_time = 33'd174000;
        e_done    = 1'b1;
        @(negedge clk);
        e_done = 1'b0;
        tcnt = 0; vcnt = 0; vlat = 0; a_cm = -1; a_avg = -1;
        for (int c = 1; c <= 50; c++) begin
            re_idle = (c >= 10 && c < 20);
            @(negedge clk);
            if (timeout === 1'b1) tcnt++;
            if (dist_valid === 1'b1) begin
                vcnt++;
                vlat  = c;
                a_cm  = int'(dist_cm);
                a_avg = int'(dist_avg);
            end
        end
        model_push(64'd174000, ecm, eoor, eavg);
        chk("to pulses", 64'(tcnt), 64'(1));
        chk("to valids", 64'(vcnt), 64'(1));
        chk("to latency", 64'(vlat), 64'(36));
        chk("to cm", 64'(a_cm), 64'(30));
        chk("to avg", 64'(a_avg), 64'(eavg));

        // Simultaneous e_done and re_idle edges in IDLE.
        @(negedge clk);
        echo_time = 33'd8700;
        e_done    = 1'b1;
        re_idle   = 1'b1;
        @(negedge clk);
        e_done  = 1'b0;
        re_idle = 1'b0;
        chk("sim timeout", 64'(timeout), 64'(1));
        chk("sim busy", 64'(busy), 64'(1));
        lat = 0;
        while (dist_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        model_push(64'd8700, ecm, eoor, eavg);
        chk("sim latency", 64'(lat), 64'(36));
        chk("sim cm", 64'(dist_cm), 64'(2));
        chk("sim avg", 64'(dist_avg), 64'(eavg));

        // Reset in the middle of a conversion.
        @(negedge clk);
        echo_time = 33'd58000;
        e_done    = 1'b1;
        @(negedge clk);
        e_done = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-rst busy", 64'(busy), 64'(0));
        chk("mid-rst dist_cm", 64'(dist_cm), 64'(0));
        chk("mid-rst dist_avg", 64'(dist_avg), 64'(0));
        chk("mid-rst oor", 64'(out_of_range), 64'(0));
        chk("mid-rst valid", 64'(dist_valid), 64'(0));
        mhist.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (dist_valid === 1'b1) extra++;
        end
        chk("mid-rst no valid", 64'(extra), 64'(0));

        // Randomized conversions against the reference model.
        for (int n = 0; n < 40; n++) begin
            if (n % 4 == 0) et = 33'({$urandom, $urandom});
            else et = 33'($urandom_range(0, 2400000));
            run_conv(et, int'($urandom_range(1, 3)), $sformatf("rnd%0d", n), a_cm, a_oor, a_avg);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_to_distance.md
ECHO_TO_DISTANCE -- requirements
Module: echo_to_distance

Interface
REQ-001 Parameter DIV_CONST, default 5800, echo clock cycles per cm of distance (58 us per cm at 100 MHz).
REQ-002 Parameter MAX_CM, default 400, saturation limit in cm.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 echo_time  input  33  echo pulse width in clk cycles; valid in the cycle e_done is high.
REQ-006 e_done  input  1  echo-measurement-complete strobe.
REQ-007 re_idle  input  1  upstream timeout/no-echo indication.
REQ-008 dist_cm  output  10  latest distance, cm, saturated to MAX_CM.
REQ-009 dist_avg  output  10  4-sample moving average of dist_cm.
REQ-010 dist_valid  output  1  one-cycle strobe; dist_cm and dist_avg updated.
REQ-011 out_of_range  output  1  high with dist_valid when saturation occurred; otherwise holds the last value.
REQ-012 timeout  output  1  one-cycle strobe on re_idle rising edge.
REQ-013 overrun  output  1  one-cycle strobe when an e_done edge is dropped.
REQ-014 busy  output  1  high while a conversion is in progress.

Function
REQ-015 The block SHALL detect e_done and re_idle by rising edge against a registered copy of each signal; a level held high SHALL count as one event.
REQ-016 FSM states SHALL be IDLE, DIV and DONE; reset state SHALL be IDLE.
REQ-017 IDLE, on an e_done edge: SHALL latch dividend = echo_time + DIV_CONST/2 (34-bit, no overflow) and go to DIV.
REQ-018 DIV SHALL run a restoring divide by DIV_CONST, one quotient bit per cycle, for exactly 34 cycles, then go to DONE.
REQ-019 DONE SHALL last one cycle and return to IDLE; busy SHALL be high in DIV and DONE.
REQ-020 Result SHALL be q = floor((echo_time + DIV_CONST/2) / DIV_CONST), i.e. round-half-up.
REQ-021 If q > MAX_CM: dist_cm = MAX_CM and out_of_range = 1; otherwise dist_cm = q[9:0] and out_of_range = 0.
REQ-022 dist_valid SHALL be a registered output of DONE, high exactly 36 cycles after the edge at which e_done was sampled high.
REQ-023 On each dist_valid, the new dist_cm SHALL be shifted into a 4-entry history.
REQ-024 dist_avg SHALL be (sum of 4 entries) >> 2 once 4 results are held; before that it SHALL equal the new dist_cm.
REQ-025 Saturated results SHALL enter the history as MAX_CM.
REQ-026 An e_done edge while busy SHALL be ignored, with overrun pulsed one cycle; the conversion in flight SHALL continue unaffected.
REQ-027 A re_idle edge SHALL pulse timeout in any state.
REQ-028 A re_idle edge SHALL NOT change dist_cm, dist_avg, the history or the FSM.
REQ-029 Simultaneous e_done and re_idle edges in IDLE SHALL both be honoured: conversion starts and timeout pulses.
REQ-030 echo_time = 0 SHALL produce dist_cm = 0 with a normal dist_valid.

Reset
REQ-031 On rst_n low, the block SHALL set, asynchronously:
  - FSM to IDLE;
  - all outputs to 0;
  - history, fill count, dividend/quotient registers and edge-detect registers to 0.
REQ-032 Reset asserted mid-DIV SHALL abort the conversion with no dist_valid afterwards.

Structure
REQ-033 Shared package sonic_pkg SHALL hold DIV_CONST and MAX_CM defaults, the output width constant (10) and the FSM state enum.
REQ-034 The divider SHALL be a sub-module udiv_seq (start/done handshake, parameterised widths).
REQ-035 The FSM, edge detection, saturation and averaging SHALL remain in echo_to_distance.

Verification
REQ-036 echo_time = 58000 with a 1-cycle e_done -> dist_valid exactly 36 cycles later, dist_cm = 10, out_of_range = 0, dist_avg = 10.
REQ-037 Rounding: echo_time 8699 -> dist_cm 1; echo_time 8700 -> dist_cm 2.
REQ-038 echo_time 3000000 -> dist_cm 400, out_of_range = 1.
REQ-039 Results 10, 20, 30, 40 cm in sequence -> dist_avg 10, 20, 30, 25.
REQ-040 Second e_done 5 cycles after the first -> overrun pulse; only one dist_valid, carrying the first result.
REQ-041 re_idle held high 10 cycles mid-DIV -> one timeout pulse, conversion result unaffected; rst_n low mid-DIV -> all outputs 0, no dist_valid.
